// File: rtl/btb_update_ctrl_if.sv
// btb_update_ctrl_if: fetch capture, resolution and BTB write/redirect bundle
// for btb_update_ctrl. Optional BTB_UPD_STATS_EN adds the statistics outputs.
interface btb_update_ctrl_if #(
  parameter int ADDR_WIDTH  = 64,
  parameter int BIA_WIDTH   = 60,
  parameter int INDEX_WIDTH = 2,
  parameter int N           = 4
);
  localparam int WAY_W = (N > 1) ? $clog2(N) : 1;

  // fetch-side lookup capture
  logic                   i_fetch_valid;
  logic                   i_stall_fetch;
  logic [ADDR_WIDTH-1:0]  i_fetch_pc;
  logic                   i_btb_hit;
  logic [WAY_W-1:0]       i_btb_way;
  logic [ADDR_WIDTH-1:0]  i_btb_target;
  logic                   o_fetch_ready;
  // resolution
  logic                   i_res_valid;
  logic                   i_res_is_branch;
  logic                   i_res_taken;
  logic [ADDR_WIDTH-1:0]  i_res_target;
  logic                   i_flush;
  // BTB write port and redirect
  logic                   o_branch_taken;
  logic [ADDR_WIDTH-1:0]  o_target_addr;
  logic [WAY_W-1:0]       o_way_write;
  logic [BIA_WIDTH-1:0]   o_bia_write;
  logic [INDEX_WIDTH-1:0] o_index_write;
  logic                   o_mispredict;
  logic [ADDR_WIDTH-1:0]  o_redirect_pc;
  logic                   o_underflow;
`ifdef BTB_UPD_STATS_EN
  logic [31:0]            o_stat_branches;
  logic [31:0]            o_stat_mispredicts;
`endif

  modport master (
    output i_fetch_valid, i_stall_fetch, i_fetch_pc, i_btb_hit, i_btb_way, i_btb_target,
    output i_res_valid, i_res_is_branch, i_res_taken, i_res_target, i_flush,
    input  o_fetch_ready, o_branch_taken, o_target_addr, o_way_write, o_bia_write,
    input  o_index_write, o_mispredict, o_redirect_pc, o_underflow
`ifdef BTB_UPD_STATS_EN
    , input o_stat_branches, o_stat_mispredicts
`endif
  );

  modport slave (
    input  i_fetch_valid, i_stall_fetch, i_fetch_pc, i_btb_hit, i_btb_way, i_btb_target,
    input  i_res_valid, i_res_is_branch, i_res_taken, i_res_target, i_flush,
    output o_fetch_ready, o_branch_taken, o_target_addr, o_way_write, o_bia_write,
    output o_index_write, o_mispredict, o_redirect_pc, o_underflow
`ifdef BTB_UPD_STATS_EN
    , output o_stat_branches, o_stat_mispredicts
`endif
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: in-order queue of fetch-time BTB lookups; at resolution the
// oldest entry is checked against the real outcome, producing a registered BTB
// write and a registered redirect. Mispredict or external flush empties the queue.
// Optional feature macro: BTB_UPD_STATS_EN (saturating branch/mispredict counters).
module btb_update_ctrl #(
  parameter int ADDR_WIDTH  = 64,
  parameter int BIA_WIDTH   = 60,
  parameter int INDEX_WIDTH = 2,
  parameter int N           = 4,
  parameter int DEPTH       = 4
) (
  input logic               i_clk,
  input logic               i_arst,
  btb_update_ctrl_if.slave  bus
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int TAG_LSB = ADDR_WIDTH - BIA_WIDTH;
  localparam int IDX_LSB = TAG_LSB - INDEX_WIDTH;
  localparam int WAY_W   = (N > 1) ? $clog2(N) : 1;

  logic [ADDR_WIDTH-1:0]  pc_mem_r  [DEPTH];
  logic [ADDR_WIDTH-1:0]  tgt_mem_r [DEPTH];
  logic [WAY_W-1:0]       way_mem_r [DEPTH];
  logic [DEPTH-1:0]       hit_mem_r;

  logic [PTR_W-1:0]       head_r, tail_r;
  logic [CNT_W-1:0]       count_r;
  logic                   fetch_ready_r;
  logic                   branch_taken_r;
  logic [ADDR_WIDTH-1:0]  target_addr_r;
  logic [WAY_W-1:0]       way_write_r;
  logic [BIA_WIDTH-1:0]   bia_write_r;
  logic [INDEX_WIDTH-1:0] index_write_r;
  logic                   mispredict_r;
  logic [ADDR_WIDTH-1:0]  redirect_pc_r;
  logic                   underflow_r;

  logic                   push_s, pop_s, actual_s, mis_s, flush_s;
  logic [ADDR_WIDTH-1:0]  head_pc_s, head_tgt_s, redirect_s;
  logic [PTR_W-1:0]       head_nxt_s, tail_nxt_s;
  logic [CNT_W-1:0]       count_nxt_s;

  // queue control: push/pop qualification, prediction check, next pointers
  always_comb begin
    head_pc_s   = pc_mem_r[head_r];
    head_tgt_s  = tgt_mem_r[head_r];
    push_s      = bus.i_fetch_valid & ~bus.i_stall_fetch & fetch_ready_r;
    pop_s       = bus.i_res_valid & (count_r != '0);
    actual_s    = bus.i_res_is_branch & bus.i_res_taken;
    mis_s       = pop_s & ((hit_mem_r[head_r] != actual_s) |
                           (hit_mem_r[head_r] & actual_s & (bus.i_res_target != head_tgt_s)));
    flush_s     = bus.i_flush | mis_s;
    redirect_s  = bus.i_res_taken ? bus.i_res_target : (head_pc_s + ADDR_WIDTH'(3'd4));
    head_nxt_s  = head_r;
    tail_nxt_s  = tail_r;
    count_nxt_s = count_r;
    if (flush_s) begin
      head_nxt_s  = '0;
      tail_nxt_s  = '0;
      count_nxt_s = '0;
    end else begin
      head_nxt_s  = head_r + PTR_W'(pop_s);
      tail_nxt_s  = tail_r + PTR_W'(push_s);
      count_nxt_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // queue pointers, occupancy and fetch-ready flag
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      head_r        <= '0;
      tail_r        <= '0;
      count_r       <= '0;
      fetch_ready_r <= 1'b1;
    end else begin
      head_r        <= head_nxt_s;
      tail_r        <= tail_nxt_s;
      count_r       <= count_nxt_s;
      fetch_ready_r <= (count_nxt_s != CNT_W'(DEPTH));
    end
  end

  // entry storage; contents are only meaningful below count, so no reset needed
  always_ff @(posedge i_clk) begin
    if (push_s && !flush_s && !i_arst) begin
      pc_mem_r[tail_r]  <= bus.i_fetch_pc;
      tgt_mem_r[tail_r] <= bus.i_btb_target;
      way_mem_r[tail_r] <= bus.i_btb_way;
      hit_mem_r[tail_r] <= bus.i_btb_hit;
    end
  end

  // registered BTB write, redirect pulse and sticky underflow
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      branch_taken_r <= 1'b0;
      target_addr_r  <= '0;
      way_write_r    <= '0;
      bia_write_r    <= '0;
      index_write_r  <= '0;
      mispredict_r   <= 1'b0;
      redirect_pc_r  <= '0;
      underflow_r    <= 1'b0;
    end else begin
      branch_taken_r <= pop_s & actual_s;
      mispredict_r   <= mis_s;
      if (pop_s && actual_s) begin
        target_addr_r <= bus.i_res_target;
        way_write_r   <= way_mem_r[head_r];
        bia_write_r   <= head_pc_s[ADDR_WIDTH-1:TAG_LSB];
        index_write_r <= head_pc_s[TAG_LSB-1:IDX_LSB];
      end
      if (pop_s) begin
        redirect_pc_r <= redirect_s;
      end
      if (bus.i_res_valid && (count_r == '0)) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign bus.o_fetch_ready  = fetch_ready_r;
  assign bus.o_branch_taken = branch_taken_r;
  assign bus.o_target_addr  = target_addr_r;
  assign bus.o_way_write    = way_write_r;
  assign bus.o_bia_write    = bia_write_r;
  assign bus.o_index_write  = index_write_r;
  assign bus.o_mispredict   = mispredict_r;
  assign bus.o_redirect_pc  = redirect_pc_r;
  assign bus.o_underflow    = underflow_r;

`ifdef BTB_UPD_STATS_EN
  logic [31:0] stat_br_r, stat_mis_r;

  // saturating counters of resolved branches and mispredicting pops
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      stat_br_r  <= 32'd0;
      stat_mis_r <= 32'd0;
    end else begin
      if (pop_s && bus.i_res_is_branch && (stat_br_r != 32'hFFFF_FFFF)) begin
        stat_br_r <= stat_br_r + 32'd1;
      end
      if (mis_s && (stat_mis_r != 32'hFFFF_FFFF)) begin
        stat_mis_r <= stat_mis_r + 32'd1;
      end
    end
  end

  assign bus.o_stat_branches    = stat_br_r;
  assign bus.o_stat_mispredicts = stat_mis_r;
`endif
endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb_btb_update_ctrl: directed stimulus; a queue-based reference model predicts
// every registered output and is compared each cycle, plus literal spot checks.
module tb_btb_update_ctrl;
  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  btb_update_ctrl_if bus ();
  btb_update_ctrl dut (.i_clk(clk), .i_arst(arst), .bus(bus));

  typedef struct {
    logic [63:0] pc;
    logic        hit;
    logic [1:0]  way;
    logic [63:0] tgt;
  } ent_t;

  ent_t        q[$];
  logic        e_bt, e_mis, e_uf, e_rdy;
  logic [63:0] e_tgt, e_rpc, e_bia;
  logic [1:0]  e_way, e_idx;
  longint      e_sb, e_sm;
  int          checks = 0;
  int          passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h want %h", name, act, req);
  endtask

  // reference: apply the current inputs to the abstract queue
  task automatic model_step();
    ent_t e;
    bit pop, push, act, mis;
    if (arst) begin
      q.delete();
      e_bt = 0; e_mis = 0; e_uf = 0; e_rdy = 1;
      e_tgt = 0; e_rpc = 0; e_bia = 0; e_way = 0; e_idx = 0;
      e_sb = 0; e_sm = 0;
      return;
    end
    pop  = bus.i_res_valid && (q.size() > 0);
    push = bus.i_fetch_valid && !bus.i_stall_fetch && (q.size() < 4);
    if (bus.i_res_valid && q.size() == 0) e_uf = 1;
    e_bt = 0; e_mis = 0; mis = 0;
    if (pop) begin
      e   = q[0];
      act = bus.i_res_is_branch && bus.i_res_taken;
      mis = (e.hit != act) || (e.hit && act && bus.i_res_target != e.tgt);
      e_bt = act;
      if (act) begin
        e_tgt = bus.i_res_target;
        e_way = e.way;
        e_bia = e.pc >> 4;
        e_idx = 2'((e.pc >> 2) & 64'd3);
      end
      e_mis = mis;
      e_rpc = bus.i_res_taken ? bus.i_res_target : e.pc + 64'd4;
      if (bus.i_res_is_branch && e_sb < 64'hFFFF_FFFF) e_sb++;
      if (mis && e_sm < 64'hFFFF_FFFF) e_sm++;
    end
    if (bus.i_flush || (pop && mis)) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        e.pc = bus.i_fetch_pc; e.hit = bus.i_btb_hit;
        e.way = bus.i_btb_way; e.tgt = bus.i_btb_target;
        q.push_back(e);
      end
    end
    e_rdy = (q.size() != 4);
  endtask

  // one clock: update model, let the edge happen, compare away from the edge
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("branch_taken", 64'(bus.o_branch_taken), 64'(e_bt));
    chk("mispredict", 64'(bus.o_mispredict), 64'(e_mis));
    chk("underflow", 64'(bus.o_underflow), 64'(e_uf));
    chk("fetch_ready", 64'(bus.o_fetch_ready), 64'(e_rdy));
    if (e_bt) begin
      chk("target_addr", bus.o_target_addr, e_tgt);
      chk("way_write", 64'(bus.o_way_write), 64'(e_way));
      chk("bia_write", 64'(bus.o_bia_write), e_bia);
      chk("index_write", 64'(bus.o_index_write), 64'(e_idx));
    end
    if (e_mis) chk("redirect_pc", bus.o_redirect_pc, e_rpc);
`ifdef BTB_UPD_STATS_EN
    chk("stat_branches", 64'(bus.o_stat_branches), 64'(e_sb));
    chk("stat_mispredicts", 64'(bus.o_stat_mispredicts), 64'(e_sm));
`endif
  endtask

  task automatic step(input logic fv, input logic [63:0] pc, input logic hit, input logic [1:0] way,
                      input logic [63:0] bt, input logic rv, input logic br, input logic tk,
                      input logic [63:0] rt, input logic fl);
    bus.i_fetch_valid = fv; bus.i_fetch_pc = pc; bus.i_btb_hit = hit;
    bus.i_btb_way = way; bus.i_btb_target = bt;
    bus.i_res_valid = rv; bus.i_res_is_branch = br; bus.i_res_taken = tk;
    bus.i_res_target = rt; bus.i_flush = fl;
    cycle();
  endtask

  task automatic push(input logic [63:0] pc, input logic hit, input logic [1:0] way, input logic [63:0] bt);
    step(1'b1, pc, hit, way, bt, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
  endtask

  task automatic res(input logic br, input logic tk, input logic [63:0] rt);
    step(1'b0, 64'd0, 1'b0, 2'd0, 64'd0, 1'b1, br, tk, rt, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 64'd0, 1'b0, 2'd0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
  endtask

  initial begin
    bus.i_stall_fetch = 1'b0;
    arst = 1'b1;
    idle(); idle();
    chk("rst_target", bus.o_target_addr, 64'h0);
    chk("rst_redirect", bus.o_redirect_pc, 64'h0);
    chk("rst_ready", 64'(bus.o_fetch_ready), 64'd1);
    arst = 1'b0;
    idle();

    // miss, resolved taken: BTB allocate plus redirect
    push(64'h1000, 1'b0, 2'd2, 64'h0);
    res(1'b1, 1'b1, 64'h2000);
    chk("t1_bt", 64'(bus.o_branch_taken), 64'd1);
    chk("t1_way", 64'(bus.o_way_write), 64'd2);
    chk("t1_idx", 64'(bus.o_index_write), 64'd0);
    chk("t1_bia", 64'(bus.o_bia_write), 64'h100);
    chk("t1_tgt", bus.o_target_addr, 64'h2000);
    chk("t1_mis", 64'(bus.o_mispredict), 64'd1);
    chk("t1_rpc", bus.o_redirect_pc, 64'h2000);
    chk("t1_ready", 64'(bus.o_fetch_ready), 64'd1);
    idle();
    chk("pulse_clear", 64'(bus.o_branch_taken), 64'd0);

    // hit, correct target; then hit, wrong target
    push(64'h1004, 1'b1, 2'd1, 64'h3000);
    res(1'b1, 1'b1, 64'h3000);
    chk("t2_bt", 64'(bus.o_branch_taken), 64'd1);
    chk("t2_way", 64'(bus.o_way_write), 64'd1);
    chk("t2_mis", 64'(bus.o_mispredict), 64'd0);
    push(64'h1004, 1'b1, 2'd1, 64'h3000);
    res(1'b1, 1'b1, 64'h3400);
    chk("t2b_mis", 64'(bus.o_mispredict), 64'd1);
    chk("t2b_rpc", bus.o_redirect_pc, 64'h3400);

    // hit, resolved not taken
    push(64'h1008, 1'b1, 2'd3, 64'h5000);
    res(1'b1, 1'b0, 64'h0);
    chk("t3_bt", 64'(bus.o_branch_taken), 64'd0);
    chk("t3_mis", 64'(bus.o_mispredict), 64'd1);
    chk("t3_rpc", bus.o_redirect_pc, 64'h100C);

    // fill, overflow attempt, pop, pop+push across the wrap, drain in order
    for (int i = 0; i < 4; i++) push(64'h2000 + 64'(4 * i), 1'b1, 2'(i), 64'h4000 + 64'(16 * i));
    chk("full_ready", 64'(bus.o_fetch_ready), 64'd0);
    push(64'h2FFF0, 1'b0, 2'd0, 64'd0);
    res(1'b1, 1'b1, 64'h4000);
    step(1'b1, 64'h2010, 1'b1, 2'd0, 64'h4040, 1'b1, 1'b1, 1'b1, 64'h4010, 1'b0);
    chk("pp_bt", 64'(bus.o_branch_taken), 64'd1);
    chk("pp_ready", 64'(bus.o_fetch_ready), 64'd1);
    push(64'h2014, 1'b1, 2'd1, 64'h4050);
    chk("refill_ready", 64'(bus.o_fetch_ready), 64'd0);
    for (int k = 0; k < 4; k++) begin
      res(1'b1, 1'b1, 64'h4000 + 64'(16 * (k + 2)));
      chk("drain_tgt", bus.o_target_addr, 64'h4000 + 64'(16 * (k + 2)));
      chk("drain_idx", 64'(bus.o_index_write), 64'((k + 2) % 4));
      chk("drain_mis", 64'(bus.o_mispredict), 64'd0);
    end

    // mispredicting pop with younger entries and an offered push
    for (int i = 0; i < 4; i++) push(64'h3000 + 64'(4 * i), (i == 0), 2'd0, 64'h6000);
    step(1'b1, 64'h3100, 1'b0, 2'd0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
    chk("t5_mis", 64'(bus.o_mispredict), 64'd1);
    chk("t5_rpc", bus.o_redirect_pc, 64'h3004);
    chk("t5_ready", 64'(bus.o_fetch_ready), 64'd1);
    res(1'b1, 1'b1, 64'h1);
    chk("t5_uf", 64'(bus.o_underflow), 64'd1);
    chk("t5_nobt", 64'(bus.o_branch_taken), 64'd0);

    // external flush with a correct pop: outputs kept, queue and push discarded
    push(64'h6000, 1'b1, 2'd3, 64'h7000);
    push(64'h6004, 1'b0, 2'd0, 64'd0);
    step(1'b1, 64'h6008, 1'b0, 2'd0, 64'd0, 1'b1, 1'b1, 1'b1, 64'h7000, 1'b1);
    chk("fl_bt", 64'(bus.o_branch_taken), 64'd1);
    chk("fl_way", 64'(bus.o_way_write), 64'd3);
    res(1'b1, 1'b1, 64'h1);
    chk("fl_empty", 64'(bus.o_branch_taken), 64'd0);
    push(64'h6100, 1'b0, 2'd2, 64'd0);
    res(1'b0, 1'b0, 64'd0);
    chk("nonbr_bt", 64'(bus.o_branch_taken), 64'd0);
    chk("nonbr_mis", 64'(bus.o_mispredict), 64'd0);

    // stalled fetch never enters the queue
    bus.i_stall_fetch = 1'b1;
    push(64'h6200, 1'b1, 2'd0, 64'h1);
    bus.i_stall_fetch = 1'b0;
    res(1'b1, 1'b1, 64'h1);
    chk("stall_bt", 64'(bus.o_branch_taken), 64'd0);

    // reset during a pop suppresses its pulses
    push(64'h7000, 1'b0, 2'd1, 64'd0);
    arst = 1'b1;
    res(1'b1, 1'b1, 64'h8000);
    chk("mid_rst_bt", 64'(bus.o_branch_taken), 64'd0);
    chk("mid_rst_uf", 64'(bus.o_underflow), 64'd0);
    arst = 1'b0;
    res(1'b1, 1'b1, 64'h8000);
    chk("mid_rst_empty", 64'(bus.o_underflow), 64'd1);

    // five branch pops, two mispredicted
    arst = 1'b1; idle(); arst = 1'b0;
    push(64'h9000, 1'b0, 2'd0, 64'd0);     res(1'b1, 1'b1, 64'hA000);
    push(64'h9004, 1'b1, 2'd1, 64'hA100);  res(1'b1, 1'b1, 64'hA100);
    push(64'h9008, 1'b1, 2'd2, 64'hA200);  res(1'b1, 1'b0, 64'd0);
    push(64'h900C, 1'b0, 2'd3, 64'd0);     res(1'b1, 1'b0, 64'd0);
    push(64'h9010, 1'b1, 2'd0, 64'hA300);  res(1'b1, 1'b1, 64'hA300);
`ifdef BTB_UPD_STATS_EN
    chk("stat_br5", 64'(bus.o_stat_branches), 64'd5);
    chk("stat_mis2", 64'(bus.o_stat_mispredicts), 64'd2);
    arst = 1'b1; idle(); arst = 1'b0;
    chk("stat_br_rst", 64'(bus.o_stat_branches), 64'd0);
    chk("stat_mis_rst", 64'(bus.o_stat_mispredicts), 64'd0);
`endif
    idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
